ifu_fetch: RTL and testbench

IFU_FETCH -- requirements
Module: ifu_fetch

---
 rtl/ifu_fetch.sv | 135 +++++++++++++
 tb/tb_ifu_fetch.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one outstanding imem read, registered hand-off to decode.
// Optional IFU_EBREAK_HALT_EN: stop fetching once decode consumes an ebreak.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  REQ   | presenting pc to imem, waiting for the request handshake
//  WAIT  | request accepted, waiting for the response (or dropping it)
//  FULL  | output register holds an instruction for decode
//  HALT  | ebreak consumed, no fetching until redirect or reset
module ifu_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [63:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        out_valid,
    output logic [63:0] out_pc,
    output logic [31:0] out_instr,
    input  logic        out_ready,
    output logic        halted
);

    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IFU_EBREAK_HALT_EN
    localparam logic [31:0] EBREAK = 32'h0010_0073;
`endif

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_FULL, S_HALT} state_t;

    state_t      state, state_n;
    logic [61:0] pc_word, pc_word_n;
    logic        discard, discard_n;
    logic        out_valid_n;
    logic [63:0] out_pc_n;
    logic [31:0] out_instr_n;

    // The pc is kept as a word index, so alignment and 2^64 wrap come for free.
    logic unused_rpc_lsb;
    assign unused_rpc_lsb = ^redirect_pc[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_REQ;
            pc_word   <= RESET_PC[63:2];
            discard   <= 1'b0;
            out_valid <= 1'b0;
            out_pc    <= 64'h0;
            out_instr <= NOP;
        end else begin
            state     <= state_n;
            pc_word   <= pc_word_n;
            discard   <= discard_n;
            out_valid <= out_valid_n;
            out_pc    <= out_pc_n;
            out_instr <= out_instr_n;
        end
    end

    always_comb begin
        state_n     = state;
        pc_word_n   = pc_word;
        discard_n   = discard;
        out_valid_n = out_valid;
        out_pc_n    = out_pc;
        out_instr_n = out_instr;
        if (redirect_valid) begin
            pc_word_n   = redirect_pc[63:2];
            out_valid_n = 1'b0;
            case (state)
                S_REQ: begin
                    // An address accepted this cycle belongs to the old path.
                    if (imem_req_ready) begin
                        discard_n = 1'b1;
                        state_n   = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        discard_n = 1'b0;
                        state_n   = S_REQ;
                    end else begin
                        discard_n = 1'b1;
                    end
                end
                default: state_n = S_REQ;
            endcase
        end else begin
            case (state)
                S_REQ: begin
                    if (imem_req_ready) state_n = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (discard) begin
                            discard_n = 1'b0;
                            state_n   = S_REQ;
                        end else begin
                            out_valid_n = 1'b1;
                            out_pc_n    = {pc_word, 2'b00};
                            out_instr_n = imem_rsp_data;
                            pc_word_n   = pc_word + 62'd1;
                            state_n     = S_FULL;
                        end
                    end
                end
                S_FULL: begin
                    if (out_ready) begin
                        out_valid_n = 1'b0;
                        state_n     = S_REQ;
`ifdef IFU_EBREAK_HALT_EN
                        if (out_instr == EBREAK) state_n = S_HALT;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem_req_valid = (state == S_REQ) && !rst;
    assign imem_req_addr  = {pc_word, 2'b00};

`ifdef IFU_EBREAK_HALT_EN
    assign halted = (state == S_HALT);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed scenarios then random traffic against a
// program-order model of the fetch stream with a latency-based memory model.
module tb_ifu_fetch;

    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
    localparam logic [31:0] EBREAK   = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    logic        imem_req_valid;
    logic [63:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        out_valid;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready = 1'b0;
    logic        halted;

    ifu_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_ready      (out_ready),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // stimulus knobs for the next cycle
    bit          k_ready = 1'b0;
    int          k_lat   = 1;
    bit          k_ordy  = 1'b0;
    bit          k_redir = 1'b0;
    logic [63:0] k_rpc   = 64'h0;
    bit          k_spur  = 1'b0;

    // memory model: at most one request in flight, answered after k_lat cycles
    bit          mem_pend = 1'b0;
    bit          mem_stale = 1'b0;
    bit          mem_orphan = 1'b0;
    logic [63:0] mem_addr = 64'h0;
    int          mem_cnt = 0;

    // stream model: next instruction decode should see, and whether it is shown
    logic [63:0] exp_pc = RESET_PC;
    bit          exp_ov = 1'b0;
    bit          exp_halt = 1'b0;

    bit          consumed;
    logic [63:0] consumed_pc;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == 64'h0000_0000_8000_000C) return EBREAK;
        return {a[26:2], 7'h33};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Starts at a negedge, drives inputs, checks outputs, advances one clock.
    task automatic cycle();
        bit rsp, hs, fresh, exp_req;
        rsp = mem_pend && (mem_cnt == 0);
        imem_rsp_valid = rsp || (k_spur && !mem_pend);
        imem_rsp_data  = rsp ? mem_word(mem_addr) : 32'hDEAD_BEEF;
        imem_req_ready = k_ready;
        out_ready      = k_ordy;
        redirect_valid = k_redir;
        redirect_pc    = k_rpc;
        #1;
        if (rst) begin
            chk("rst_req_valid", imem_req_valid, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_pc", out_pc, 64'h0);
            chk("rst_out_instr", out_instr, 64'h13);
            chk("rst_halted", halted, 0);
        end else begin
            exp_req = !exp_ov && !(mem_pend && !mem_orphan) && !exp_halt;
            chk("out_valid", out_valid, exp_ov);
            if (exp_ov) begin
                chk("out_pc", out_pc, exp_pc);
                chk("out_instr", out_instr, mem_word(exp_pc));
            end
            chk("req_valid", imem_req_valid, exp_req);
            if (exp_req) chk("req_addr", imem_req_addr, exp_pc);
            chk("halted", halted, exp_halt);
        end
        hs = imem_req_valid && k_ready;
        if (hs) chk("one_outstanding", mem_pend && !rsp, 0);
        consumed    = !rst && out_valid && k_ordy && !k_redir;
        consumed_pc = out_pc;

        if (rst) begin
            exp_pc   = RESET_PC;
            exp_ov   = 1'b0;
            exp_halt = 1'b0;
            if (mem_pend && !rsp) begin
                mem_orphan = 1'b1;
                mem_stale  = 1'b1;
            end
        end else begin
            fresh = rsp && !mem_stale;
            if (k_redir) begin
                exp_pc   = {k_rpc[63:2], 2'b00};
                exp_ov   = 1'b0;
                exp_halt = 1'b0;
                if (mem_pend && !rsp) mem_stale = 1'b1;
            end else if (exp_ov && k_ordy) begin
`ifdef IFU_EBREAK_HALT_EN
                if (mem_word(exp_pc) == EBREAK) exp_halt = 1'b1;
`endif
                exp_pc = exp_pc + 64'd4;
                exp_ov = 1'b0;
            end else if (!exp_ov && fresh) begin
                exp_ov = 1'b1;
            end
        end
        if (rsp) mem_pend = 1'b0;
        else if (mem_pend) mem_cnt--;
        if (hs) begin
            mem_pend   = 1'b1;
            mem_addr   = imem_req_addr;
            mem_cnt    = k_lat - 1;
            mem_stale  = k_redir;
            mem_orphan = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic redirect_to(input logic [63:0] target);
        k_redir = 1'b1;
        k_rpc   = target;
        cycle();
        k_redir = 1'b0;
    endtask

    task automatic consume_check(input string tag, input int maxc, input logic [63:0] exp_v);
        bit ok;
        logic [63:0] seen;
        ok = 1'b0;
        seen = 64'h0;
        for (int i = 0; i < maxc && !ok; i++) begin
            cycle();
            if (consumed) begin
                ok   = 1'b1;
                seen = consumed_pc;
            end
        end
        chk(tag, ok ? seen : 64'hxxxx_xxxx_xxxx_xxxx, exp_v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] cpc [4];
        int          ccyc [4];
        int          n;
        bit          found;
        logic [63:0] hold_pc;
        logic [31:0] hold_instr;

        @(negedge clk);
        cycle();
        cycle();
        rst = 1'b0;
        #1;
        chk("release_req_valid", imem_req_valid, 1);
        chk("release_req_addr", imem_req_addr, RESET_PC);

        // zero-wait throughput from reset
        k_ready = 1'b1; k_lat = 1; k_ordy = 1'b1;
        n = 0;
        for (int i = 0; i < 9; i++) begin
            cycle();
            if (consumed && n < 4) begin
                cpc[n]  = consumed_pc;
                ccyc[n] = i;
                n++;
            end
        end
        chk("tp_count", n, 3);
        chk("tp_pc0", cpc[0], 64'h8000_0000);
        chk("tp_pc1", cpc[1], 64'h8000_0004);
        chk("tp_pc2", cpc[2], 64'h8000_0008);
        chk("tp_first", ccyc[0], 2);
        chk("tp_gap01", ccyc[1] - ccyc[0], 3);
        chk("tp_gap12", ccyc[2] - ccyc[1], 3);

        // reset with a request in flight; the late response must be ignored
        k_lat = 3;
        cycle();
        rst = 1'b1; k_ready = 1'b0;
        cycle();
        rst = 1'b0;
        repeat (4) cycle();
        chk("late_rsp_ov", out_valid, 0);
        chk("late_rsp_addr", imem_req_addr, RESET_PC);

        // decode stall for 10 cycles
        k_ready = 1'b1; k_lat = 2; k_ordy = 1'b0;
        for (int i = 0; i < 20 && !out_valid; i++) cycle();
        chk("full_reached", out_valid, 1);
        hold_pc = out_pc;
        hold_instr = out_instr;
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("stall_pc", out_pc, hold_pc);
            chk("stall_instr", out_instr, hold_instr);
            chk("stall_noreq", imem_req_valid, 0);
        end
        k_ordy = 1'b1;
        cycle();
        k_ordy = 1'b0;
        chk("refetch_next", imem_req_valid, 1);
        chk("refetch_addr", imem_req_addr, hold_pc + 64'd4);

        // redirect coinciding with a decode handshake
        for (int i = 0; i < 20 && !out_valid; i++) cycle();
        chk("full_again", out_valid, 1);
        k_ordy = 1'b1;
        redirect_to(64'h0000_0000_8000_2000);
        chk("redir_ov_drop", out_valid, 0);
        consume_check("redir_full_target", 20, 64'h0000_0000_8000_2000);

        // redirect in WAIT, response arriving later is dropped
        k_lat = 4;
        redirect_to(RESET_PC);
        cycle();
        redirect_to(64'h0000_0000_8000_1002);
        for (int i = 0; i < 10 && !imem_req_valid; i++) cycle();
        chk("redir_wait_req", imem_req_valid, 1);
        chk("redir_wait_addr", imem_req_addr, 64'h0000_0000_8000_1000);
        chk("redir_wait_ov", out_valid, 0);

        // ebreak at 0x8000000C
        k_lat = 1;
        redirect_to(RESET_PC);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle();
            if (consumed && consumed_pc == 64'h0000_0000_8000_000C) found = 1'b1;
        end
        chk("ebreak_reached", found, 1);
`ifdef IFU_EBREAK_HALT_EN
        for (int i = 0; i < 4; i++) begin
            chk("halt_flag", halted, 1);
            chk("halt_noreq", imem_req_valid, 0);
            cycle();
        end
        redirect_to(RESET_PC);
        chk("halt_clear", halted, 0);
        chk("resume_req", imem_req_valid, 1);
        chk("resume_addr", imem_req_addr, RESET_PC);
`else
        chk("no_halt", halted, 0);
        consume_check("after_ebreak", 10, 64'h0000_0000_8000_0010);
`endif

        // pc wrap at the top of the address space
        redirect_to(64'hFFFF_FFFF_FFFF_FFFE);
        consume_check("wrap_fetch", 10, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_req", imem_req_valid, 1);
        chk("wrap_addr", imem_req_addr, 64'h0);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            k_ready = ($urandom_range(0, 9) < 7);
            k_lat   = $urandom_range(1, 4);
            k_ordy  = ($urandom_range(0, 9) < 7);
            k_spur  = ($urandom_range(0, 9) == 0);
            k_redir = ($urandom_range(0, 99) < 3);
            case ($urandom_range(0, 3))
                0: k_rpc = {$urandom, $urandom};
                1: k_rpc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
                default: k_rpc = RESET_PC + 64'($urandom_range(0, 63));
            endcase
            if (!mem_pend && $urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                cycle();
                rst = 1'b0;
            end else begin
                cycle();
            end
        end
        k_redir = 1'b0;
        k_spur  = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
